// File: rtl/rca_accumulator.sv
// Streaming accumulator: sums N_OPS 4-bit operands through a ripple-carry adder,
// counting adder carry-outs, and hands the result over a valid/ready pair.

package rca_accumulator_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

module ripple_carry_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign out[i]   = in0[i] ^ in1[i] ^ c[i];
    assign c[i + 1] = (in0[i] & in1[i]) | (c[i] & (in0[i] ^ in1[i]));
  end

  assign cout = c[W];
endmodule

module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int N_OPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic [3:0] out_carries,
  output logic       busy
);
  localparam logic [3:0] LAST = 4'(N_OPS);

  if (N_OPS < 1 || N_OPS > 15) begin : g_bad_n_ops
    $error("rca_accumulator: N_OPS must be in 1..15");
  end

  state_t     state;
  state_t     state_nxt;
  logic [3:0] acc;
  logic [3:0] cnt;
  logic [3:0] carries;
  logic [3:0] sum_nxt;
  logic       cout;
  logic       accept;
  logic       last_op;

  ripple_carry_adder #(.W(4)) u_adder (
    .in0  (acc),
    .in1  (in_data),
    .out  (sum_nxt),
    .cout (cout)
  );

  assign in_ready    = (state != DONE);
  assign accept      = in_valid & in_ready;
  assign last_op     = (cnt + 4'd1) == LAST;
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign out_sum     = acc;
  assign out_carries = carries;

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = last_op ? DONE : ACCUM;
      ACCUM:   if (accept && last_op) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset wins over any accept or handoff in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      carries <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc     <= sum_nxt;
        carries <= carries + {3'b000, cout};
        cnt     <= cnt + 4'd1;
      end else if (state == DONE && out_ready) begin
        acc     <= '0;
        cnt     <= '0;
        carries <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator: N_OPS=4 vector table, stall/reset corner
// cases, exhaustive N_OPS=2 pairs with random gaps, and the N_OPS=1 fast path.
module tb_rca_accumulator;
  import rca_accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready4, out_valid4, busy4;
  logic [3:0] out_sum4, out_carries4;
  logic       in_ready2, out_valid2, busy2;
  logic [3:0] out_sum2, out_carries2;
  logic       in_ready1, out_valid1, busy1;
  logic [3:0] out_sum1, out_carries1;

  int checks   = 0;
  int failures = 0;

  logic mon1      = 1'b0;
  logic saw_accum = 1'b0;

  always #5 clk = ~clk;

  rca_accumulator #(.N_OPS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_sum(out_sum4),
    .out_carries(out_carries4), .busy(busy4)
  );

  rca_accumulator #(.N_OPS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_carries(out_carries2), .busy(busy2)
  );

  rca_accumulator #(.N_OPS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_carries(out_carries1), .busy(busy1)
  );

  always @(posedge clk) begin
    if (mon1 && u_dut1.state == ACCUM) saw_accum <= 1'b1;
  end

  typedef struct {
    logic [3:0] ops [4];
    logic [3:0] exp_sum;
    logic [3:0] exp_carries;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Feeds four operands back-to-back into the N_OPS=4 instance and checks the result.
  task automatic run4(input logic [3:0] ops [4], input logic [3:0] es, input logic [3:0] ec);
    for (int i = 0; i < 4; i++) begin
      check("in_ready4_feed", in_ready4, 1);
      in_valid = 1'b1;
      in_data  = ops[i];
      tick();
      if (i < 3) check("out_valid4_early", out_valid4, 0);
    end
    in_valid = 1'b0;
    check("out_valid4", out_valid4, 1);
    check("out_sum4", out_sum4, es);
    check("out_carries4", out_carries4, ec);
    check("in_ready4_done", in_ready4, 0);
  endtask

  vec_t vecs [6];
  logic [3:0] ones [4];

  initial begin
    vecs[0] = '{ops: '{4'd1, 4'd2, 4'd3, 4'd4},     exp_sum: 4'b1010, exp_carries: 4'd0};
    vecs[1] = '{ops: '{4'd15, 4'd15, 4'd15, 4'd15}, exp_sum: 4'b1100, exp_carries: 4'd3};
    vecs[2] = '{ops: '{4'd8, 4'd8, 4'd8, 4'd8},     exp_sum: 4'd0,    exp_carries: 4'd2};
    vecs[3] = '{ops: '{4'd9, 4'd7, 4'd0, 4'd1},     exp_sum: 4'd1,    exp_carries: 4'd1};
    vecs[4] = '{ops: '{4'd0, 4'd0, 4'd0, 4'd0},     exp_sum: 4'd0,    exp_carries: 4'd0};
    vecs[5] = '{ops: '{4'd14, 4'd3, 4'd5, 4'd6},    exp_sum: 4'd12,   exp_carries: 4'd1};
    ones    = '{4'd1, 4'd1, 4'd1, 4'd1};
    in_data = 4'd0;

    // Reset state, asserted over two edges.
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid4, 0);
    check("rst_busy", busy4, 0);
    check("rst_out_sum", out_sum4, 0);
    check("rst_out_carries", out_carries4, 0);
    check("rst_in_ready", in_ready4, 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready4, 1);
    check("post_rst_sum", out_sum4, 0);

    // Table-driven N_OPS=4 vectors.
    foreach (vecs[v]) begin
      run4(vecs[v].ops, vecs[v].exp_sum, vecs[v].exp_carries);
      pop();
      check("pop_busy4", busy4, 0);
      check("pop_in_ready4", in_ready4, 1);
      check("pop_out_valid4", out_valid4, 0);
    end

    // Stalled consumer: result holds and operands are refused.
    run4(vecs[0].ops, vecs[0].exp_sum, vecs[0].exp_carries);
    in_valid = 1'b1;
    in_data  = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_valid", out_valid4, 1);
      check("stall_out_sum", out_sum4, 4'b1010);
      check("stall_out_carries", out_carries4, 0);
      check("stall_in_ready", in_ready4, 0);
    end
    in_valid = 1'b0;
    pop();
    check("stall_pop_busy", busy4, 0);
    check("stall_pop_in_ready", in_ready4, 1);
    check("stall_pop_sum_cleared", out_sum4, 0);
    run4(vecs[0].ops, vecs[0].exp_sum, vecs[0].exp_carries);
    pop();

    // Reset after two of four operands discards the partial sum.
    in_valid = 1'b1;
    in_data  = 4'd7;
    tick();
    in_data  = 4'd9;
    tick();
    check("partial_busy", busy4, 1);
    rst     = 1'b1;
    in_data = 4'd3;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", out_valid4, 0);
    check("midrst_busy", busy4, 0);
    check("midrst_out_sum", out_sum4, 0);
    check("midrst_out_carries", out_carries4, 0);
    check("midrst_in_ready", in_ready4, 1);
    run4(ones, 4'b0100, 4'd0);
    pop();

    // Reset while DONE drops the unconsumed result.
    run4(vecs[1].ops, vecs[1].exp_sum, vecs[1].exp_carries);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("donerst_out_valid", out_valid4, 0);
    check("donerst_out_carries", out_carries4, 0);

    // N_OPS=2: every (a, b) pair with random idle gaps before each operand.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) tick();
        in_valid = 1'b1;
        in_data  = 4'(a);
        tick();
        in_valid = 1'b0;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          tick();
          check("n2_gap_out_valid", out_valid2, 0);
        end
        in_valid = 1'b1;
        in_data  = 4'(b);
        tick();
        in_valid = 1'b0;
        check("n2_out_valid", out_valid2, 1);
        check("n2_out_sum", out_sum2, (a + b) % 16);
        check("n2_out_carries", out_carries2, (a + b > 15) ? 1 : 0);
        pop();
      end
    end

    // N_OPS=1: result the cycle after the single accept, never through ACCUM.
    do_reset();
    mon1     = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0111;
    tick();
    in_valid = 1'b0;
    check("n1_out_valid", out_valid1, 1);
    check("n1_out_sum", out_sum1, 4'b0111);
    check("n1_out_carries", out_carries1, 0);
    pop();
    check("n1_pop_busy", busy1, 0);
    in_valid = 1'b1;
    in_data  = 4'd15;
    tick();
    in_valid = 1'b0;
    check("n1_second_sum", out_sum1, 4'd15);
    pop();
    tick();
    mon1 = 1'b0;
    check("n1_never_accum", saw_accum, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
